pipe_adder: RTL and testbench



---
 rtl/pipe_adder_pkg.sv | 26 ++
 rtl/pipe_adder_if.sv | 36 +++
 rtl/pipe_adder_stage.sv | 82 ++++++++
 rtl/pipe_adder.sv | 88 ++++++++
 tb/tb_pipe_adder.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and types for the pipelined carry-chunked adder.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits per stage
//   calc_stages()         : pipeline depth (= latency) for a width/chunk pair
//   stage_t               : per-stage payload layout at the default widths
// Optional feature macro: PIPE_ADDER_OVF_EN (signed overflow output).
package pipe_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // a_rem/b_rem: operand chunks not yet consumed, shifted so the next chunk
  // sits at the LSBs. sum_lo: finished result chunks, newest at the MSBs.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] a_rem;
    logic [DEF_WIDTH-1:0] b_rem;
    logic [DEF_WIDTH-1:0] sum_lo;
    logic                 carry;
    logic                 sub;
    logic                 valid;
  } stage_t;

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready, data_a, data_b, carry_in, sub : request side
//   out_valid/out_ready, data_out, carry_out [, ovf]  : result side
// master = producer/consumer side, slave = the adder.
// Optional feature macro: PIPE_ADDER_OVF_EN adds ovf.
interface pipe_adder_if #(parameter int WIDTH = pipe_adder_pkg::DEF_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             carry_out;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef PIPE_ADDER_OVF_EN
    input  ovf,
`endif
    output in_valid, data_a, data_b, carry_in, sub, out_ready,
    input  in_ready, out_valid, data_out, carry_out
  );

  modport slave (
`ifdef PIPE_ADDER_OVF_EN
    output ovf,
`endif
    input  in_valid, data_a, data_b, carry_in, sub, out_ready,
    output in_ready, out_valid, data_out, carry_out
  );
endinterface

// File: rtl/pipe_adder_stage.sv
// adder_stage: one CHUNK-bit slice of the pipelined adder plus its registers.
//   clk, rst (sync, active high clear), en (hold when low)
//   a_in/b_in     : remaining operand bits, current chunk at LSBs
//   sum_in        : result chunks finished by earlier stages
//   c_in          : carry from previous stage (effective carry_in at stage 0)
//   *_out         : registered payload for the next stage
// Optional feature macro: PIPE_ADDER_OVF_EN adds ovf_out (signed overflow of
// this chunk's MSB; only the last stage's value is meaningful).
module adder_stage #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             c_in,
  input  logic             sub_in,
  input  logic             vld_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             sub_out,
`ifdef PIPE_ADDER_OVF_EN
  output logic             ovf_out,
`endif
  output logic             vld_out
);

  logic [CHUNK:0]   add;
  logic [WIDTH-1:0] sum_nxt;

  assign add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, c_in};

  // Result chunks shift down one chunk per stage; the newest lands on top so
  // chunk 0 reaches the LSBs after the final stage.
  if (CHUNK == WIDTH) begin : g_one
    logic unused_sum;
    assign sum_nxt    = add[CHUNK-1:0];
    assign unused_sum = ^sum_in;
  end else begin : g_multi
    logic unused_sum;
    assign sum_nxt    = {add[CHUNK-1:0], sum_in[WIDTH-1:CHUNK]};
    assign unused_sum = ^sum_in[CHUNK-1:0];
  end

`ifdef PIPE_ADDER_OVF_EN
  // Same-sign operands giving a different-sign sum; equals carry-in XOR
  // carry-out of the chunk MSB.
  logic ovf_nxt;
  assign ovf_nxt = (a_in[CHUNK-1] == b_in[CHUNK-1]) && (add[CHUNK-1] != a_in[CHUNK-1]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out   <= '0;
      b_out   <= '0;
      sum_out <= '0;
      c_out   <= 1'b0;
      sub_out <= 1'b0;
      vld_out <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_out <= 1'b0;
`endif
    end else if (en) begin
      a_out   <= a_in >> CHUNK;
      b_out   <= b_in >> CHUNK;
      sum_out <= sum_nxt;
      c_out   <= add[CHUNK];
      sub_out <= sub_in;
      vld_out <= vld_in;
`ifdef PIPE_ADDER_OVF_EN
      ovf_out <= ovf_nxt;
`endif
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage,
// latency STAGES = WIDTH/CHUNK, valid/ready handshake with a global stall.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset (flushes everything in flight)
//   bus : pipe_adder_if.slave (operands in, sum/difference out)
// Optional feature macro: PIPE_ADDER_OVF_EN drives bus.ovf.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clk,
  input  logic         rst,
  pipe_adder_if.slave  bus
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
    logic             sub;
    logic             valid;
  } pl_t;

  pl_t [STAGES:0] pl;  // pl[0] = stage 0 input, pl[k+1] = stage k registers
  logic           stall;
  logic           accept;

  // One stall for the whole pipe: bubbles stay in place.
  assign stall        = pl[STAGES].valid && !bus.out_ready;
  assign bus.in_ready = !rst && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

  // Subtract folds into the add: A + ~B + ~borrow_in.
  assign pl[0].a_rem  = bus.data_a;
  assign pl[0].b_rem  = bus.sub ? ~bus.data_b : bus.data_b;
  assign pl[0].sum_lo = '0;
  assign pl[0].carry  = bus.carry_in ^ bus.sub;
  assign pl[0].sub    = bus.sub;
  assign pl[0].valid  = accept;

`ifdef PIPE_ADDER_OVF_EN
  logic [STAGES-1:0] ovf_s;
  logic              unused_ovf;
  assign bus.ovf    = ovf_s[STAGES-1];
  assign unused_ovf = ^ovf_s;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (!stall),
      .a_in    (pl[k].a_rem),
      .b_in    (pl[k].b_rem),
      .sum_in  (pl[k].sum_lo),
      .c_in    (pl[k].carry),
      .sub_in  (pl[k].sub),
      .vld_in  (pl[k].valid),
      .a_out   (pl[k+1].a_rem),
      .b_out   (pl[k+1].b_rem),
      .sum_out (pl[k+1].sum_lo),
      .c_out   (pl[k+1].carry),
      .sub_out (pl[k+1].sub),
`ifdef PIPE_ADDER_OVF_EN
      .ovf_out (ovf_s[k]),
`endif
      .vld_out (pl[k+1].valid)
    );
  end

  assign bus.out_valid = pl[STAGES].valid;
  assign bus.data_out  = pl[STAGES].sum_lo;
  assign bus.carry_out = pl[STAGES].carry;

  // Operand remainders are fully consumed by the last stage.
  logic unused_tail;
  assign unused_tail = ^{pl[STAGES].a_rem, pl[STAGES].b_rem, pl[STAGES].sub};

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(32)) b32 ();
  pipe_adder_if #(.WIDTH(4))  b4 ();

  pipe_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  pipe_adder #(.WIDTH(4),  .CHUNK(2)) u_dut4  (.clk(clk), .rst(rst), .bus(b4));

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];
  int checks = 0;
  int errors = 0;
  int got32  = 0;
  int got4   = 0;

  // Reference: plain integer arithmetic at width w.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic s);
    exp_t e;
    longint unsigned m, ua, ub, full;
    longint sa, sb, sr, half;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    if (!s) begin
      full = ua + ub + {63'd0, cin};
      e.d  = 32'(full & m);
      e.c  = ((full >> w) & 64'd1) != 64'd0;
    end else begin
      e.d  = 32'((ua - ub - {63'd0, cin}) & m);
      e.c  = (ua >= ub + {63'd0, cin});
    end
    half = longint'(64'd1 << (w - 1));
    sa = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
    sb = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
    sr = s ? sa - sb - longint'({63'd0, cin}) : sa + sb + longint'({63'd0, cin});
    e.v = (sr > half - 1) || (sr < -half);
    return e;
  endfunction

  // Scoreboards: push on accept, pop/compare on emit, flush on reset.
  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
    end else begin
      if (b32.in_valid && b32.in_ready)
        q32.push_back(model(32, b32.data_a, b32.data_b, b32.carry_in, b32.sub));
      if (b32.out_valid && b32.out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL sb32_unexpected: data_out=%h with nothing outstanding", b32.data_out);
        end else begin
          exp_t e;
          e = q32.pop_front();
          got32++;
          if ({b32.data_out, b32.carry_out} !== {e.d, e.c}) begin
            errors++;
            $display("FAIL sb32_result: got %h/%b want %h/%b", b32.data_out, b32.carry_out, e.d, e.c);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else begin
      if (b4.in_valid && b4.in_ready)
        q4.push_back(model(4, {28'd0, b4.data_a}, {28'd0, b4.data_b}, b4.carry_in, b4.sub));
      if (b4.out_valid && b4.out_ready) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected: data_out=%h with nothing outstanding", b4.data_out);
        end else begin
          exp_t e;
          e = q4.pop_front();
          got4++;
          if ({b4.data_out, b4.carry_out} !== {e.d[3:0], e.c}) begin
            errors++;
            $display("FAIL sb4_result: got %h/%b want %h/%b", b4.data_out, b4.carry_out, e.d[3:0], e.c);
          end
`ifdef PIPE_ADDER_OVF_EN
          if (b4.ovf !== e.v) begin
            errors++;
            $display("FAIL sb4_ovf: got %b want %b", b4.ovf, e.v);
          end
`endif
        end
      end
    end
  end

  // Drive one transaction, return #1 after the edge that accepted it.
  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic s);
    int n;
    b32.in_valid = 1'b1; b32.data_a = a; b32.data_b = b; b32.carry_in = cin; b32.sub = s;
    n = 0;
    @(negedge clk);
    while (!b32.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send32_timeout: in_ready=%b want 1", b32.in_ready);
    end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic s);
    int n;
    b4.in_valid = 1'b1; b4.data_a = a; b4.data_b = b; b4.carry_in = cin; b4.sub = s;
    n = 0;
    @(negedge clk);
    while (!b4.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send4_timeout: in_ready=%b want 1", b4.in_ready);
    end
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q32.size() != 0 || q4.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q32.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: outstanding %0d/%0d want 0/0", name, q32.size(), q4.size());
    end
  endtask

  // Latency from the accepting edge to out_valid; also checks the result.
  task automatic expect_result(input string name, input logic [31:0] d, input logic c);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!b32.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d want 4", name, lat);
    end
    checks++;
    if ({b32.data_out, b32.carry_out} !== {d, c}) begin
      errors++;
      $display("FAIL %s_value: got %h/%b want %h/%b", name, b32.data_out, b32.carry_out, d, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b32.in_valid = 1'b1; b32.data_a = 32'h1234_5678; b32.data_b = 32'h1111_1111;
    b32.carry_in = 1'b0; b32.sub = 1'b0; b32.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.data_a = '0; b4.data_b = '0; b4.carry_in = 1'b0; b4.sub = 1'b0;
    b4.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({b32.out_valid, b32.data_out, b32.carry_out, b32.in_ready} !== 35'd0) begin
        errors++;
        $display("FAIL reset_state: vld=%b data=%h cout=%b rdy=%b want all 0",
                 b32.out_valid, b32.data_out, b32.carry_out, b32.in_ready);
      end
      checks++;
      if ({b4.out_valid, b4.in_ready} !== 2'b00) begin
        errors++;
        $display("FAIL reset_state4: vld=%b rdy=%b want 0/0", b4.out_valid, b4.in_ready);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    b32.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b want 1", b32.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    send32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    expect_result("single_add", 32'h0000_0100, 1'b0);
    drain("single_add");
  endtask

  task automatic test_carry_wrap();
    send32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    expect_result("wrap", 32'h0, 1'b1);
    drain("wrap");
    send32(32'd5, 32'd7, 1'b0, 1'b1);
    expect_result("sub", 32'hFFFF_FFFE, 1'b0);
    drain("sub");
  endtask

  task automatic test_backpressure();
    int start;
    logic [32:0] held;
    start = got32;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        @(negedge clk);
        held = {b32.data_out, b32.carry_out};
        checks++;
        if (b32.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_valid_at_stall: out_valid=%b want 1", b32.out_valid);
        end
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          checks++;
          if (b32.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b want 0 (cycle %0d)", b32.in_ready, c);
          end
          checks++;
          if ({b32.out_valid, b32.data_out, b32.carry_out} !== {1'b1, held}) begin
            errors++;
            $display("FAIL bp_hold: got %b/%h/%b want 1/%h/%b (cycle %0d)", b32.out_valid,
                     b32.data_out, b32.carry_out, held[32:1], held[0], c);
          end
        end
        @(posedge clk); #1;
        b32.out_ready = 1'b1;
      end
    join
    drain("backpressure");
    checks++;
    if (got32 - start != 10) begin
      errors++;
      $display("FAIL bp_count: got %0d results want 10", got32 - start);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start = got4;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            send4(4'(a), 4'(b), 1'(c), 1'(s));
    drain("exhaustive4");
    checks++;
    if (got4 - start != 1024) begin
      errors++;
      $display("FAIL exh_count: got %0d results want 1024", got4 - start);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    start = got32;
    send32(32'd10, 32'd20, 1'b0, 1'b0);
    send32(32'd30, 32'd40, 1'b0, 1'b0);
    send32(32'd50, 32'd60, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (b32.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_flush: out_valid=%b want 0 (cycle %0d)", b32.out_valid, c);
      end
    end
    @(posedge clk); #1;
    send32(32'h0001_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    expect_result("midrst_new", 32'h0002_0001, 1'b0);
    drain("midrst");
    checks++;
    if (got32 - start != 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d results want 1", got32 - start);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_carry_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
